// File: rtl/mmio_uart_pkg.sv
// Shared constants for the MMIO UART transmitter: FSM state encodings,
// register offsets and STATUS bit positions.
package mmio_uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
  localparam logic [2:0] ST_PARITY = 3'd4;

  localparam logic REG_TXDATA = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_OVF   = 3;

  function automatic logic [31:0] status_word(logic ovf, logic empty, logic full, logic busy);
    logic [31:0] w;
    w = '0;
    w[STAT_OVF]   = ovf;
    w[STAT_EMPTY] = empty;
    w[STAT_FULL]  = full;
    w[STAT_BUSY]  = busy;
    return w;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Data-memory IO-window bus between the processor (master) and the UART (slave).
// Reads are combinational on io_rdata_t; writes are single-cycle strobes, never stalled.
interface mmio_uart_tx_if;
  logic        io_sel_t;
  logic        io_we_t;
  logic        io_addr_t;
  logic [31:0] io_wdata_t;
  logic [31:0] io_rdata_t;

  modport master (output io_sel_t, output io_we_t, output io_addr_t, output io_wdata_t,
                  input io_rdata_t);
  modport slave  (input io_sel_t, input io_we_t, input io_addr_t, input io_wdata_t,
                  output io_rdata_t);
endinterface

// File: rtl/mmio_tx_fifo.sv
// Byte FIFO: push visible at head one cycle later, head is a combinational read.
// When full, a push is taken only if a pop happens in the same cycle; otherwise it is refused.
module mmio_tx_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk_t,
  input  logic       rst_t,
  input  logic       push_i,
  input  logic [7:0] push_dat_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output logic       empty_nxt_o,
  output logic [7:0] head_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign empty_o = (cnt_q == '0);
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign head_o  = mem_q[rd_q];

  always_comb begin
    cnt_d = cnt_q;
    if (push_ok && !pop_ok)
      cnt_d = cnt_q + (AW+1)'(1);
    else if (pop_ok && !push_ok)
      cnt_d = cnt_q - (AW+1)'(1);
  end

  assign empty_nxt_o = (cnt_d == '0);

  always_ff @(posedge clk_t or posedge rst_t) begin
    if (rst_t) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop_ok)  rd_q <= rd_q + AW'(1);
    end
  end

  always_ff @(posedge clk_t) begin
    if (push_ok) mem_q[wr_q] <= push_dat_i;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO serial transmitter: TXDATA stores queue bytes, FSM sends 8N1 LSB-first (tx falls one cycle after a store to an idle UART).
// Stores to a full FIFO are dropped and flagged in STATUS.OVF; MMIO_UART_PARITY_EN adds an even-parity bit.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic          clk_t,
  input  logic          rst_t,
  mmio_uart_tx_if.slave bus,
  output logic          tx_t,
  output logic          irq_t
);

  localparam int BW = $clog2(CLK_DIV);

  logic [2:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d, irq_q, irq_d, ovf_q, ovf_d;
  logic          baud_end, busy, wr_tx, wr_st;
  logic          fifo_pop, fifo_full, fifo_empty, fifo_empty_nxt;
  logic [7:0]    fifo_head;
  logic [31:0]   rdata;
  logic          unused_wdata;
`ifdef MMIO_UART_PARITY_EN
  logic          par_q, par_d;
`endif

  assign baud_end = (baud_q == BW'(CLK_DIV - 1));
  assign busy     = (state_q != ST_IDLE);
  assign wr_tx    = bus.io_sel_t & bus.io_we_t & (bus.io_addr_t == REG_TXDATA);
  assign wr_st    = bus.io_sel_t & bus.io_we_t & (bus.io_addr_t == REG_STATUS);
  assign unused_wdata = ^{bus.io_wdata_t[31:8], bus.io_wdata_t[2:0]};

  mmio_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_t       (clk_t),
    .rst_t       (rst_t),
    .push_i      (wr_tx),
    .push_dat_i  (bus.io_wdata_t[7:0]),
    .pop_i       (fifo_pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .empty_nxt_o (fifo_empty_nxt),
    .head_o      (fifo_head)
  );

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_end ? '0 : baud_q + BW'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
`ifdef MMIO_UART_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
`ifdef MMIO_UART_PARITY_EN
          par_d    = ^fifo_head;
`endif
          state_d  = ST_START;
        end
      end
      ST_START: if (baud_end) begin
        state_d = ST_DATA;
        bit_d   = '0;
      end
      ST_DATA: if (baud_end) begin
        shift_d = {1'b0, shift_q[7:1]};
        bit_d   = bit_q + 3'd1;
`ifdef MMIO_UART_PARITY_EN
        if (bit_q == 3'd7) state_d = ST_PARITY;
`else
        if (bit_q == 3'd7) state_d = ST_STOP;
`endif
      end
`ifdef MMIO_UART_PARITY_EN
      ST_PARITY: if (baud_end) state_d = ST_STOP;
`endif
      ST_STOP: if (baud_end) begin
        // Chain straight into the next start bit so queued bytes leave without an idle gap.
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
`ifdef MMIO_UART_PARITY_EN
          par_d    = ^fifo_head;
`endif
          state_d  = ST_START;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
`ifdef MMIO_UART_PARITY_EN
      ST_PARITY: tx_d = par_d;
`endif
      default:   tx_d = 1'b1;
    endcase

    irq_d = fifo_empty_nxt & (state_d == ST_IDLE);

    ovf_d = ovf_q;
    if (wr_st && bus.io_wdata_t[STAT_OVF])
      ovf_d = 1'b0;
    else if (wr_tx && fifo_full && !fifo_pop)
      ovf_d = 1'b1;
  end

  always_ff @(posedge clk_t or posedge rst_t) begin
    if (rst_t) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      irq_q   <= 1'b1;
      ovf_q   <= 1'b0;
`ifdef MMIO_UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      irq_q   <= irq_d;
      ovf_q   <= ovf_d;
`ifdef MMIO_UART_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    rdata = '0;
    if (bus.io_sel_t && !bus.io_we_t) begin
      if (bus.io_addr_t == REG_STATUS)
        rdata = status_word(ovf_q, fifo_empty, fifo_full, busy);
      else if (!fifo_empty)
        rdata = {24'b0, fifo_head};
    end
  end

  assign bus.io_rdata_t = rdata;
  assign tx_t  = tx_q;
  assign irq_t = irq_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: a frame-level model predicts when each byte starts on the line,
// and an independent line monitor decodes every frame and checks it against the predicted queue.
module tb_mmio_uart_tx;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 8;
`ifdef MMIO_UART_PARITY_EN
  localparam int NSYM = 11;
`else
  localparam int NSYM = 10;
`endif
  localparam int FRAME = NSYM * CLK_DIV;

  logic clk_t = 1'b0;
  logic rst_t = 1'b1;
  logic tx_t, irq_t;

  mmio_uart_tx_if bus_if ();

  mmio_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk_t (clk_t),
    .rst_t (rst_t),
    .bus   (bus_if),
    .tx_t  (tx_t),
    .irq_t (irq_t)
  );

  always #5 clk_t = ~clk_t;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk_t) cyc <= cyc + 1;

  // Reference model: bytes waiting to start, and the edge at which the line next becomes free.
  typedef struct {
    byte unsigned b;
    int           start;
  } exp_t;

  byte unsigned mq[$];
  exp_t         sb[$];
  int           free_edge   = 0;
  bit           m_ovf       = 1'b0;
  int           frames_seen = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] w;
    w    = '0;
    w[0] = (cyc < free_edge);
    w[1] = (mq.size() == DEPTH);
    w[2] = (mq.size() == 0);
    w[3] = m_ovf;
    return w;
  endfunction

  task automatic model_edge(int e, bit wr_tx, byte unsigned d, bit wr_st, bit clr);
    exp_t x;
    if (mq.size() > 0 && e >= free_edge) begin
      x.b       = mq.pop_front();
      x.start   = e;
      sb.push_back(x);
      free_edge = e + FRAME;
    end
    if (wr_tx) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else m_ovf = 1'b1;
    end
    if (wr_st && clr) m_ovf = 1'b0;
  endtask

  // Called just after a falling edge: drive, check combinational outputs, advance the model, wait.
  task automatic cycle(bit sel, bit we, bit addr, logic [31:0] wd);
    logic [31:0] exp_rd;
    bus_if.io_sel_t   = sel;
    bus_if.io_we_t    = we;
    bus_if.io_addr_t  = addr;
    bus_if.io_wdata_t = wd;
    #1;
    if (!sel) begin
      check("rdata_unselected", bus_if.io_rdata_t, 0);
    end else if (!we) begin
      exp_rd = addr ? m_status() : ((mq.size() > 0) ? {24'b0, mq[0]} : 32'h0);
      check(addr ? "status_read" : "txdata_read", bus_if.io_rdata_t, exp_rd);
    end
    check("irq", irq_t, (mq.size() == 0) && !(cyc < free_edge));
    model_edge(cyc + 1, sel & we & ~addr, wd[7:0], sel & we & addr, wd[3]);
    @(negedge clk_t);
  endtask

  task automatic idle_cycles(int n);
    for (int i = 0; i < n; i++)
      cycle(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), $urandom);
  endtask

  task automatic write_tx(byte unsigned b);
    cycle(1'b1, 1'b1, 1'b0, {$urandom_range(0, 32'hFFFFFF), 8'(b)});
  endtask

  task automatic frame_done(logic [63:0] ln, int st);
    exp_t        x;
    logic [63:0] exp_ln;
    int          sym;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_frame: got frame at cycle %0d expected none", st);
    end else begin
      x      = sb.pop_front();
      exp_ln = '0;
      for (int i = 0; i < FRAME; i++) begin
        sym = i / CLK_DIV;
        if (sym == 0)                   exp_ln[i] = 1'b0;
        else if (sym <= 8)              exp_ln[i] = x.b[sym-1];
        else if (NSYM == 11 && sym == 9) exp_ln[i] = ^x.b;
        else                            exp_ln[i] = 1'b1;
      end
      check("frame_start_cycle", 64'(st), 64'(x.start));
      check("frame_line", ln, exp_ln);
    end
  endtask

  // Line monitor: samples tx on falling edges, one sample per clock, starting at the falling start bit.
  logic [63:0] mon_line;
  int          mon_pos   = 0;
  int          mon_start = 0;
  bit          mon_busy  = 1'b0;

  always @(negedge clk_t) begin
    if (rst_t) begin
      mon_busy = 1'b0;
    end else if (!mon_busy) begin
      if (tx_t === 1'b0) begin
        mon_busy    = 1'b1;
        mon_start   = cyc;
        mon_line    = '0;
        mon_line[0] = tx_t;
        mon_pos     = 1;
      end
    end else begin
      mon_line[mon_pos] = tx_t;
      mon_pos++;
    end
    if (mon_busy && mon_pos == FRAME) begin
      mon_busy = 1'b0;
      frames_seen++;
      frame_done(mon_line, mon_start);
    end
  end

  initial begin
    int n0, s0, guard;
    byte unsigned rb;
    bus_if.io_sel_t   = 1'b1;
    bus_if.io_we_t    = 1'b0;
    bus_if.io_addr_t  = 1'b1;
    bus_if.io_wdata_t = '0;

    #50;
    check("reset_tx", tx_t, 1'b1);
    check("reset_irq", irq_t, 1'b1);
    check("reset_status", bus_if.io_rdata_t, 32'h4);
    @(negedge clk_t);
    rst_t = 1'b0;
    idle_cycles(5);

    // Single byte; upper store bits must be ignored.
    write_tx(8'hA5);
    idle_cycles(FRAME + 5);

    // Two stores on consecutive cycles must produce abutting frames.
    write_tx(8'h55);
    write_tx(8'h0F);
    idle_cycles(2 * FRAME + 5);

    // Parity-sensitive pattern (odd number of ones).
    write_tx(8'h07);
    idle_cycles(FRAME + 5);

    // Overflow: ten stores in a row, then clear the sticky flag.
    n0 = frames_seen;
    for (int i = 0; i < 10; i++) write_tx(8'($urandom));
    cycle(1'b1, 1'b0, 1'b1, '0);
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b1, 32'h8);
    cycle(1'b1, 1'b0, 1'b1, '0);
    idle_cycles(9 * FRAME + 10);
    check("overflow_frame_count", 64'(frames_seen - n0), 64'd9);

    // Random mix of stores, STATUS writes and reads.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    write_tx(8'($urandom));
        2:       cycle(1'b1, 1'b1, 1'b1, $urandom);
        default: cycle(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), $urandom);
      endcase
    end
    guard = 0;
    while ((mq.size() > 0 || cyc < free_edge) && guard < 2000) begin
      idle_cycles(1);
      guard++;
    end
    check("drain_within_budget", 64'(guard < 2000), 64'd1);
    idle_cycles(3);

    // Reset in the middle of data bit 3 of the first of three queued frames.
    rb = 8'h37;
    write_tx(rb);
    write_tx(8'($urandom));
    write_tx(8'($urandom));
    s0    = sb[0].start;
    guard = 0;
    while (cyc < s0 + 4 * CLK_DIV + 1 && guard < 100) begin
      idle_cycles(1);
      guard++;
    end
    bus_if.io_sel_t  = 1'b1;
    bus_if.io_we_t   = 1'b0;
    bus_if.io_addr_t = 1'b1;
    #1;
    check("tx_before_reset", tx_t, rb[3]);
    #1;
    rst_t = 1'b1;
    #1;
    check("async_reset_tx", tx_t, 1'b1);
    check("async_reset_irq", irq_t, 1'b1);
    check("async_reset_status", bus_if.io_rdata_t, 32'h4);
    mq.delete();
    sb.delete();
    free_edge = 0;
    m_ovf     = 1'b0;
    @(negedge clk_t);
    @(negedge clk_t);
    rst_t = 1'b0;
    n0    = frames_seen;
    idle_cycles(3 * FRAME);
    check("no_frames_after_reset", 64'(frames_seen - n0), 64'd0);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
